// File: rtl/sample_mixer_if.sv
// Stream bundle between the func_gen sources and sample_mixer: three signed waves
// and a mode select in, a held sample with its strobe, clip flag and f_s out.
interface sample_mixer_if;
    logic signed [11:0] wave_a;
    logic signed [11:0] wave_b;
    logic signed [11:0] wave_c;
    logic        [2:0]  sel;
    logic               f_s;
    logic signed [11:0] din;
    logic               stb;
    logic               clip;

    modport master (
        output wave_a, wave_b, wave_c, sel,
        input  f_s, din, stb, clip
    );

    modport slave (
        input  wave_a, wave_b, wave_c, sel,
        output f_s, din, stb, clip
    );
endinterface

// File: rtl/sample_mixer.sv
// Stimulus conditioning ahead of FIR_HPF: mixes three waves with saturation, divides clk into f_s
// and holds each mixed sample for one f_s period. Define MIX_AVG_EN for boxcar averaging.
module sample_mixer #(
    parameter int DIV_N  = 100,
    parameter int AVG_SH = 3
) (
    input  logic          clk,
    input  logic          rst,
    sample_mixer_if.slave mix
);
    localparam int CW = $clog2(DIV_N);
    localparam logic [CW-1:0] LAST = CW'(DIV_N - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV_N / 2 - 1);

    if ((DIV_N % 2) != 0 || DIV_N < 4) begin : g_bad_div
        $error("sample_mixer: DIV_N must be even and >= 4");
    end
    if (AVG_SH < 0) begin : g_bad_sh
        $error("sample_mixer: AVG_SH must be non-negative");
    end

    logic [CW-1:0]      cnt;
    logic signed [13:0] a14, b14, c14, sum;
    logic signed [11:0] mix_val;
    logic               mix_clip;
    logic               do_sat;
    logic signed [11:0] cap_val;
    logic               cap_clip;

    always_comb begin
        a14      = {{2{mix.wave_a[11]}}, mix.wave_a};
        b14      = {{2{mix.wave_b[11]}}, mix.wave_b};
        c14      = {{2{mix.wave_c[11]}}, mix.wave_c};
        sum      = '0;
        do_sat   = 1'b0;
        mix_val  = '0;
        mix_clip = 1'b0;
        case (mix.sel)
            3'd0: mix_val = mix.wave_a;
            3'd1: mix_val = mix.wave_b;
            3'd2: mix_val = mix.wave_c;
            3'd3: begin
                sum     = a14 + b14;
                mix_val = sum[12:1];
            end
            3'd4: begin
                sum    = a14 + b14;
                do_sat = 1'b1;
            end
            3'd5: begin
                sum    = a14 - b14 - c14;
                do_sat = 1'b1;
            end
            3'd6: begin
                sum    = a14 + b14 + c14;
                do_sat = 1'b1;
            end
            default: mix_val = '0;
        endcase
        if (do_sat) begin
            if (sum > 14'sd2047) begin
                mix_val  = 12'sd2047;
                mix_clip = 1'b1;
            end else if (sum < -14'sd2048) begin
                mix_val  = -12'sd2048;
                mix_clip = 1'b1;
            end else begin
                mix_val = sum[11:0];
            end
        end
    end

`ifdef MIX_AVG_EN
    localparam int ACC_W = 12 + AVG_SH;
    localparam logic [CW-1:0] WIN_START = CW'(DIV_N - (2 ** AVG_SH));

    if ((2 ** AVG_SH) > DIV_N) begin : g_bad_win
        $error("sample_mixer: 2**AVG_SH must not exceed DIV_N");
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] avg_sum;
    logic signed [ACC_W-1:0] avg_shift;
    logic                    clip_acc;

    // The capture-edge sample is folded in combinationally so the window is exactly 2**AVG_SH samples.
    always_comb begin
        avg_sum   = acc + ACC_W'(mix_val);
        avg_shift = avg_sum >>> AVG_SH;
        cap_val   = avg_shift[11:0];
        cap_clip  = clip_acc | mix_clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            clip_acc <= 1'b0;
        end else if (cnt == LAST) begin
            acc      <= '0;
            clip_acc <= 1'b0;
        end else if (cnt >= WIN_START) begin
            acc      <= avg_sum;
            clip_acc <= clip_acc | mix_clip;
        end
    end
`else
    always_comb begin
        cap_val  = mix_val;
        cap_clip = mix_clip;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mix.f_s  <= 1'b0;
            mix.din  <= '0;
            mix.stb  <= 1'b0;
            mix.clip <= 1'b0;
        end else begin
            mix.stb <= 1'b0;
            if (cnt == LAST) begin
                cnt      <= '0;
                mix.f_s  <= 1'b1;
                mix.stb  <= 1'b1;
                mix.din  <= cap_val;
                mix.clip <= cap_clip;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == HALF) begin
                    mix.f_s <= 1'b0;
                end
            end
        end
    end
endmodule
